// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package hazard_ctrl_pkg;

    typedef enum logic [2:0] {
        STG_FE,
        STG_DE,
        STG_EX,
        STG_MEM,
        STG_WB
    } stage_e;

    // Inter-stage registers are indexed by the stage that feeds them.
    localparam int N_PREG = 4;
    localparam int PR_FD  = int'(STG_FE);
    localparam int PR_DE  = int'(STG_DE);
    localparam int PR_EM  = int'(STG_EX);
    localparam int PR_MW  = int'(STG_MEM);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        REDIRECT,
        ISR
    } irq_state_e;

    localparam int DRAIN_CYCLES_DEF = 3;

    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline status inputs and hold/clear/redirect controls exchanged with the hazard controller.
interface hazard_ctrl_if #(
    parameter int REG_AW = 4
);
    logic              fe_busy;
    logic              ex_busy;
    logic              mem_busy;
    logic [REG_AW-1:0] de_rs1;
    logic [REG_AW-1:0] de_rs2;
    logic              de_uses_rs1;
    logic              de_uses_rs2;
    logic              ex_is_load;
    logic [REG_AW-1:0] ex_rd;
    logic              branch_taken;
    logic              irq;
    logic              reti_ex;

    logic              pc_hold;
    logic              hold_fd, hold_de, hold_em, hold_mw;
    logic              clear_fd, clear_de, clear_em, clear_mw;
    logic              irq_redirect;
    logic              in_isr;

    modport master (
        output fe_busy, ex_busy, mem_busy, de_rs1, de_rs2, de_uses_rs1, de_uses_rs2,
               ex_is_load, ex_rd, branch_taken, irq, reti_ex,
        input  pc_hold, hold_fd, hold_de, hold_em, hold_mw,
               clear_fd, clear_de, clear_em, clear_mw, irq_redirect, in_isr
    );

    modport slave (
        input  fe_busy, ex_busy, mem_busy, de_rs1, de_rs2, de_uses_rs1, de_uses_rs2,
               ex_is_load, ex_rd, branch_taken, irq, reti_ex,
        output pc_hold, hold_fd, hold_de, hold_em, hold_mw,
               clear_fd, clear_de, clear_em, clear_mw, irq_redirect, in_isr
    );

endinterface

// File: rtl/hazard_ctrl_hazard_detect.sv
// Combinational load-use comparator: a load in EX feeding a used source of the DE instruction.
module hazard_detect #(
    parameter int REG_AW = 4
) (
    input  logic              ex_is_load,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [REG_AW-1:0] de_rs1,
    input  logic [REG_AW-1:0] de_rs2,
    input  logic              de_uses_rs1,
    input  logic              de_uses_rs2,
    output logic              load_use
);

    logic rd_live;
    logic rs1_hit;
    logic rs2_hit;

    // Register 0 is hardwired, so a load targeting it can never create a dependency.
    assign rd_live  = ex_is_load & (ex_rd != '0);
    assign rs1_hit  = de_uses_rs1 & (de_rs1 == ex_rd);
    assign rs2_hit  = de_uses_rs2 & (de_rs2 == ex_rd);
    assign load_use = rd_live & (rs1_hit | rs2_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard priority logic plus interrupt-entry FSM (IDLE/DRAIN/REDIRECT/ISR).
// Optional stall counter output is built only when HAZARD_PERF_EN is defined.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_AW       = 4,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int PERF_W       = 32
) (
    input  logic              clk,
    input  logic              nreset,
    hazard_ctrl_if.slave      bus
`ifdef HAZARD_PERF_EN
    ,
    output logic [PERF_W-1:0] stall_count
`endif
);

    localparam int               CNT_W    = cnt_width(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (PERF_W < 1 || DRAIN_CYCLES < 0) begin : g_bad_param
        $error("hazard_ctrl: PERF_W must be >= 1 and DRAIN_CYCLES >= 0");
    end

    irq_state_e        state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              in_isr_reg;
    logic              load_use;
    logic              ex_stall;
    logic              br_eff;
    logic              pc_hold;
    logic              irq_redirect;
    logic [N_PREG-1:0] hold_raw;
    logic [N_PREG-1:0] clear_raw;
    logic [N_PREG-1:0] hold_vec;

    hazard_detect #(.REG_AW(REG_AW)) u_detect (
        .ex_is_load  (bus.ex_is_load),
        .ex_rd       (bus.ex_rd),
        .de_rs1      (bus.de_rs1),
        .de_rs2      (bus.de_rs2),
        .de_uses_rs1 (bus.de_uses_rs1),
        .de_uses_rs2 (bus.de_uses_rs2),
        .load_use    (load_use)
    );

    // A branch only counts once EX is actually advancing and nothing above it wins.
    assign ex_stall = bus.mem_busy | bus.ex_busy;
    assign br_eff   = bus.branch_taken & ~ex_stall & ~load_use;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            in_isr_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            in_isr_reg <= (state_next == ISR);
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (bus.irq && !in_isr_reg) begin
                    state_next = DRAIN;
                    cnt_next   = CNT_LOAD;
                end
            end
            DRAIN: begin
                if (br_eff) begin
                    cnt_next = CNT_LOAD;
                end else if (!ex_stall) begin
                    if (cnt_reg <= CNT_ONE) begin
                        state_next = REDIRECT;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg - CNT_ONE;
                    end
                end
            end
            REDIRECT: state_next = ISR;
            ISR: begin
                if (bus.reti_ex && !ex_stall) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pc_hold      = 1'b0;
        irq_redirect = 1'b0;
        hold_raw     = '0;
        clear_raw    = '0;
        if (bus.mem_busy) begin
            pc_hold          = 1'b1;
            hold_raw[PR_FD]  = 1'b1;
            hold_raw[PR_DE]  = 1'b1;
            hold_raw[PR_EM]  = 1'b1;
            clear_raw[PR_MW] = 1'b1;
        end else if (bus.ex_busy) begin
            pc_hold          = 1'b1;
            hold_raw[PR_FD]  = 1'b1;
            hold_raw[PR_DE]  = 1'b1;
            clear_raw[PR_EM] = 1'b1;
        end else if (load_use) begin
            pc_hold          = 1'b1;
            hold_raw[PR_FD]  = 1'b1;
            clear_raw[PR_DE] = 1'b1;
        end else if (br_eff) begin
            clear_raw[PR_FD] = 1'b1;
            clear_raw[PR_DE] = 1'b1;
        end else if (bus.fe_busy) begin
            pc_hold          = 1'b1;
            clear_raw[PR_FD] = 1'b1;
        end

        // Drain starves fetch but lets a resolved branch target reach the PC.
        case (state_reg)
            DRAIN: begin
                clear_raw[PR_FD] = 1'b1;
                pc_hold          = ~br_eff;
            end
            REDIRECT: begin
                clear_raw[PR_FD] = 1'b1;
                irq_redirect     = 1'b1;
                pc_hold          = 1'b0;
            end
            default: ;
        endcase
    end

    for (genvar gi = 0; gi < N_PREG; gi++) begin : g_hold_mask
        assign hold_vec[gi] = hold_raw[gi] & ~clear_raw[gi];
    end

    assign bus.pc_hold      = pc_hold;
    assign bus.hold_fd      = hold_vec[PR_FD];
    assign bus.hold_de      = hold_vec[PR_DE];
    assign bus.hold_em      = hold_vec[PR_EM];
    assign bus.hold_mw      = hold_vec[PR_MW];
    assign bus.clear_fd     = clear_raw[PR_FD];
    assign bus.clear_de     = clear_raw[PR_DE];
    assign bus.clear_em     = clear_raw[PR_EM];
    assign bus.clear_mw     = clear_raw[PR_MW];
    assign bus.irq_redirect = irq_redirect;
    assign bus.in_isr       = in_isr_reg;

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] stall_count_reg;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            stall_count_reg <= '0;
        end else if (pc_hold && (stall_count_reg != '1)) begin
            stall_count_reg <= stall_count_reg + PERF_W'(1);
        end
    end

    assign stall_count = stall_count_reg;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomised + directed bench for hazard_ctrl against a rule-table reference model.
// With HAZARD_PERF_EN defined the stall counter is also checked (narrow width so it saturates).
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    localparam int TB_AW     = 4;
    localparam int TB_DC     = 3;
    localparam int TB_PERF_W = 8;

    logic clk;
    logic nreset;

    hazard_ctrl_if #(.REG_AW(TB_AW)) bus ();

`ifdef HAZARD_PERF_EN
    logic [TB_PERF_W-1:0] stall_count;
`endif

    hazard_ctrl #(
        .REG_AW       (TB_AW),
        .DRAIN_CYCLES (TB_DC),
        .PERF_W       (TB_PERF_W)
    ) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
`ifdef HAZARD_PERF_EN
        ,
        .stall_count (stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic obs_redirect;

    // Reference model: flags plus an up-counter of clean cycles seen while draining.
    bit m_draining;
    bit m_redirect;
    bit m_isr;
    int m_clean;
    int m_stalls;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_draining = 0;
        m_redirect = 0;
        m_isr      = 0;
        m_clean    = 0;
        m_stalls   = 0;
    endtask

    function automatic bit model_load_use();
        if (!bus.ex_is_load || bus.ex_rd == 0) return 0;
        return (bus.de_uses_rs1 && bus.de_rs1 == bus.ex_rd) ||
               (bus.de_uses_rs2 && bus.de_rs2 == bus.ex_rd);
    endfunction

    function automatic bit model_branch();
        return bus.branch_taken && !bus.mem_busy && !bus.ex_busy && !model_load_use();
    endfunction

    // Vectors: bit0 FE/DE, bit1 DE/EX, bit2 EX/MEM, bit3 MEM/WB.
    task automatic model_outputs(output logic [3:0] h, output logic [3:0] c,
                                 output logic pc, output logic red);
        h = 4'b0000; c = 4'b0000; pc = 0; red = 0;
        if (bus.mem_busy)          begin pc = 1; h = 4'b0111; c = 4'b1000; end
        else if (bus.ex_busy)      begin pc = 1; h = 4'b0011; c = 4'b0100; end
        else if (model_load_use()) begin pc = 1; h = 4'b0001; c = 4'b0010; end
        else if (model_branch())   begin pc = 0; c = 4'b0011; end
        else if (bus.fe_busy)      begin pc = 1; c = 4'b0001; end
        if (m_draining) begin c[0] = 1; pc = !model_branch(); end
        if (m_redirect) begin c[0] = 1; pc = 0; red = 1; end
        h = h & ~c;
    endtask

    task automatic model_update(input logic pc);
        bit stalled;
        stalled = bus.mem_busy || bus.ex_busy;
        if (pc && m_stalls < (2 ** TB_PERF_W) - 1) m_stalls++;
        if (m_redirect) begin
            m_redirect = 0;
            m_isr      = 1;
        end else if (m_draining) begin
            if (model_branch()) m_clean = 0;
            else if (!stalled) begin
                m_clean++;
                if (m_clean >= TB_DC) begin
                    m_draining = 0;
                    m_redirect = 1;
                end
            end
        end else if (m_isr) begin
            if (bus.reti_ex && !stalled) m_isr = 0;
        end else if (bus.irq) begin
            m_draining = 1;
            m_clean    = 0;
        end
    endtask

    task automatic idle_inputs();
        bus.fe_busy = 0; bus.ex_busy = 0; bus.mem_busy = 0;
        bus.de_rs1 = '0; bus.de_rs2 = '0; bus.de_uses_rs1 = 0; bus.de_uses_rs2 = 0;
        bus.ex_is_load = 0; bus.ex_rd = '0; bus.branch_taken = 0;
        bus.irq = 0; bus.reti_ex = 0;
    endtask

    // One transaction: inputs already driven; check at negedge, advance model at posedge.
    task automatic step(input string name);
        logic [3:0] eh, ec, gh, gc;
        logic ep, er;
        @(negedge clk);
        model_outputs(eh, ec, ep, er);
        gh = {bus.hold_mw, bus.hold_em, bus.hold_de, bus.hold_fd};
        gc = {bus.clear_mw, bus.clear_em, bus.clear_de, bus.clear_fd};
        obs_redirect = bus.irq_redirect;
        chk({name, ".pc_hold"}, 32'(bus.pc_hold), 32'(ep));
        chk({name, ".hold"}, 32'(gh), 32'(eh));
        chk({name, ".clear"}, 32'(gc), 32'(ec));
        chk({name, ".irq_redirect"}, 32'(bus.irq_redirect), 32'(er));
        chk({name, ".in_isr"}, 32'(bus.in_isr), 32'(m_isr));
`ifdef HAZARD_PERF_EN
        chk({name, ".stall_count"}, 32'(stall_count), 32'(m_stalls));
`endif
        $display("[%0d] %s in(mem=%b ex=%b fe=%b lu=%b br=%b irq=%b reti=%b) out(pc=%b h=%b c=%b red=%b isr=%b)",
                 cyc, name, bus.mem_busy, bus.ex_busy, bus.fe_busy, model_load_use(),
                 bus.branch_taken, bus.irq, bus.reti_ex, bus.pc_hold, gh, gc,
                 bus.irq_redirect, bus.in_isr);
        @(posedge clk);
        model_update(ep);
        cyc++;
        #1;
    endtask

    // Asynchronous reset pulse placed mid-cycle, then reset state checked while still held.
    task automatic pulse_reset(input string name);
        idle_inputs();
        #2 nreset = 0;
        #1;
        chk({name, ".in_isr"}, 32'(bus.in_isr), 32'(0));
        chk({name, ".irq_redirect"}, 32'(bus.irq_redirect), 32'(0));
        chk({name, ".pc_hold"}, 32'(bus.pc_hold), 32'(0));
        chk({name, ".clear"}, 32'({bus.clear_mw, bus.clear_em, bus.clear_de, bus.clear_fd}), 32'(0));
        chk({name, ".hold"}, 32'({bus.hold_mw, bus.hold_em, bus.hold_de, bus.hold_fd}), 32'(0));
`ifdef HAZARD_PERF_EN
        chk({name, ".stall_count"}, 32'(stall_count), 32'(0));
`endif
        $display("[%0d] %s reset pulse", cyc, name);
        model_reset();
        @(negedge clk);
        nreset = 1;
        @(posedge clk);
        #1;
    endtask

    // Count steps until irq_redirect is seen, bounded.
    task automatic irq_latency(input string name, input int ex_busy_cycles, output int lat);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            bus.ex_busy = (k <= ex_busy_cycles);
            step(name);
            if (obs_redirect === 1'b1) begin
                lat = k;
                break;
            end
        end
        bus.ex_busy = 0;
    endtask

    initial begin
        int lat;
        idle_inputs();
        model_reset();
        nreset = 0;
        repeat (2) @(posedge clk);
        #1;
        pulse_reset("rst_init");

        step("idle");

        // Load-use, then the same against register 0.
        bus.ex_is_load = 1; bus.ex_rd = 4'd5; bus.de_rs1 = 4'd5; bus.de_uses_rs1 = 1;
        step("load_use");
        idle_inputs();
        step("after_lu");
        bus.ex_is_load = 1; bus.ex_rd = 4'd0; bus.de_rs1 = 4'd0; bus.de_uses_rs1 = 1;
        step("lu_r0");
        idle_inputs();

        // mem_busy masks a pending branch until it falls.
        bus.mem_busy = 1; bus.branch_taken = 1;
        repeat (4) step("mem_br");
        bus.mem_busy = 0;
        step("br_go");
        idle_inputs();
        step("after_br");

        bus.ex_busy = 1; bus.fe_busy = 1;
        step("ex_fe");
        idle_inputs();

        // Interrupt entry with idle pipeline.
        bus.irq = 1;
        step("irq");
        bus.irq = 0;
        irq_latency("drain", 0, lat);
        chk("irq_latency_idle", 32'(lat), 32'(TB_DC + 1));
        repeat (3) step("isr");
        bus.irq = 1;
        step("isr_irq_ignored");
        bus.irq = 0; bus.reti_ex = 1;
        step("reti");
        bus.reti_ex = 0;
        step("post_reti");

        // Entry stretched by ex_busy.
        bus.irq = 1;
        step("irq2");
        bus.irq = 0;
        irq_latency("drain_exb", 2, lat);
        chk("irq_latency_exbusy", 32'(lat), 32'(TB_DC + 3));
        bus.reti_ex = 1;
        step("reti2");
        idle_inputs();

        // Reset during drain: no redirect afterwards.
        bus.irq = 1;
        step("irq3");
        bus.irq = 0;
        step("drain3");
        pulse_reset("rst_drain");
        repeat (5) step("post_rst");

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            bus.mem_busy     = ($urandom_range(0, 7) == 0);
            bus.ex_busy      = ($urandom_range(0, 7) == 0);
            bus.fe_busy      = ($urandom_range(0, 4) == 0);
            bus.branch_taken = ($urandom_range(0, 5) == 0);
            bus.ex_is_load   = ($urandom_range(0, 2) == 0);
            bus.ex_rd        = TB_AW'($urandom_range(0, 3));
            bus.de_rs1       = TB_AW'($urandom_range(0, 3));
            bus.de_rs2       = TB_AW'($urandom_range(0, 3));
            bus.de_uses_rs1  = 1'($urandom_range(0, 1));
            bus.de_uses_rs2  = 1'($urandom_range(0, 1));
            bus.irq          = ($urandom_range(0, 19) == 0);
            bus.reti_ex      = ($urandom_range(0, 9) == 0);
            step("rand");
            if (i == 200) pulse_reset("rst_rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage CPU (FE, DE, EX, MEM, WB). Each cycle it drives the hold and clear inputs of the four inter-stage pipeline registers (FE/DE, DE/EX, EX/MEM, MEM/WB) and the PC hold line. It resolves stalls, bubbles and branch flushes, and runs a small interrupt-entry state machine that drains the pipeline before redirecting fetch. It is purely a control block and carries no datapath.

## Interface
- REG_AW, 4: register-address width for load-use comparison
- DRAIN_CYCLES, 3: empty cycles required before interrupt redirect
- PERF_W, 32: stall-counter width (perf build only)

Ports (all control outputs registered or combinational as stated in Timing):
- clk  in  1  system clock
- nreset  in  1  asynchronous, active-low reset
- fe_busy  in  1  instruction fetch not ready this cycle
- ex_busy  in  1  multi-cycle EX unit (mul/div) still running
- mem_busy  in  1  data memory access not complete
- de_rs1, de_rs2  in  REG_AW  source registers of instruction in DE
- de_uses_rs1, de_uses_rs2  in  1  source valid flags
- ex_is_load  in  1  instruction in EX is a load
- ex_rd  in  REG_AW  destination of instruction in EX
- branch_taken  in  1  EX resolved taken branch/jump
- irq  in  1  level interrupt request
- reti_ex  in  1  return-from-interrupt in EX
- pc_hold  out  1  freeze PC
- hold_fd, hold_de, hold_em, hold_mw  out  1  per-register hold
- clear_fd, clear_de, clear_em, clear_mw  out  1  per-register clear (bubble)
- irq_redirect  out  1  one-cycle pulse: PC loads interrupt vector
- in_isr  out  1  interrupt service active
- stall_count  out  PERF_W  only with HAZARD_PERF_EN

## Operation
- Priority (highest first), evaluated combinationally each cycle:
  - mem_busy: pc_hold, hold_fd, hold_de, hold_em = 1; clear_mw = 1.
  - ex_busy: pc_hold, hold_fd, hold_de = 1; clear_em = 1.
  - load-use (ex_is_load & ex_rd != 0 & matching used de_rs1/de_rs2): pc_hold, hold_fd = 1; clear_de = 1.
  - branch_taken: clear_fd, clear_de = 1; pc_hold = 0.
  - fe_busy: pc_hold = 1; clear_fd = 1.
- branch_taken is ignored while mem_busy or ex_busy is asserted; the branch is re-presented when EX advances.
- Load-use against register 0 never stalls.
- A register never receives hold and clear together; clear wins if both would be asserted.
- Interrupt FSM states:
  - IDLE: on irq & ~in_isr, go to DRAIN.
  - DRAIN: pc_hold = 1 and clear_fd = 1 (no new instructions). A down-counter loads DRAIN_CYCLES on entry and decrements only on cycles with no mem_busy/ex_busy. If branch_taken arrives, pc_hold is dropped for that cycle so the target is latched, and the counter reloads. At 0, go to REDIRECT.
  - REDIRECT: irq_redirect = 1, clear_fd = 1; go to ISR.
  - ISR: in_isr = 1; irq is ignored. On reti_ex (not stalled), go to IDLE.

## Timing
- Hold and clear outputs are combinational from inputs and FSM state, so the response takes effect at the next clk edge with zero added latency.
- FSM state, drain counter, in_isr and stall_count are registered.
- nreset low: state = IDLE, counter = 0, in_isr = 0, stall_count = 0. With IDLE and idle inputs, all hold/clear/pc_hold/irq_redirect outputs are 0.
- Reset asserted mid-DRAIN or mid-ISR returns immediately to IDLE with no redirect pulse.
- Minimum irq-to-irq_redirect latency is DRAIN_CYCLES + 1 cycles after irq is sampled.
- irq deasserted during DRAIN does not abort entry.

## Configuration
- HAZARD_PERF_EN defined:
  - stall_count increments by 1 on every cycle in which pc_hold = 1.
  - It saturates at all-ones and never wraps.
- HAZARD_PERF_EN undefined: the stall_count port and counter are absent.

## Structure
- Shared package: stage enumeration, FSM state typedef (IDLE, DRAIN, REDIRECT, ISR), default DRAIN_CYCLES constant.
- One sub-module, hazard_detect: the combinational load-use comparator. The FSM and priority logic stay in hazard_ctrl.

## Test plan
- Load-use: ex_is_load = 1, ex_rd = 5, de_rs1 = 5, de_uses_rs1 = 1 -> pc_hold = hold_fd = clear_de = 1 for exactly one cycle. Same with ex_rd = 0 -> no stall.
- mem_busy for 4 cycles with branch_taken = 1 -> 4 cycles of hold_fd/de/em and clear_mw; no clear_fd until mem_busy falls, then clear_fd = clear_de = 1 for one cycle.
- ex_busy and fe_busy together -> ex_busy response only (clear_em = 1, clear_fd = 0).
- irq pulse with idle pipeline, DRAIN_CYCLES = 3 -> 3 DRAIN cycles, irq_redirect on cycle 4, then in_isr = 1 until reti_ex.
- irq during ex_busy for 2 cycles -> drain extended by 2, so irq_redirect arrives 6 cycles after entering DRAIN.
- nreset pulsed during DRAIN -> in_isr = 0, no irq_redirect; with HAZARD_PERF_EN, stall_count = 0, and it saturates when preloaded near max in simulation.
